// File: rtl/hs_rx_pkg.sv
// Shared constants and state type for the HS receive deserializer.
package hs_rx_pkg;
  localparam logic [7:0] SYNC_BYTE    = 8'hB8;
  localparam int         HUNT_TIMEOUT = 32;
  localparam int         HIST_W       = 10;

  typedef enum logic [1:0] {IDLE, HUNT, ACTIVE, ERR} rx_state_t;
endpackage

// File: rtl/rx_ddr_capture.sv
// DDR line capture: negedge bit held, then presented with the posedge bit as a pair.
// One posedge of latency; free-running, no flow control.
module rx_ddr_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic older,
  output logic newer
);
  logic neg_bit;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_bit <= 1'b0;
    else        neg_bit <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older <= 1'b0;
      newer <= 1'b0;
    end else begin
      older <= neg_bit;
      newer <= din;
    end
  end
endmodule

// File: rtl/hs_rx_deserializer.sv
// HS receive deserializer: sync hunt on both bit phases, then byte framing every 4 posedges.
// Strobes are registered one posedge after the deciding edge; the line cannot be stalled.
module hs_rx_deserializer
  import hs_rx_pkg::*;
(
  input  logic       RxDDRClkHS,
  input  logic       RxRst,
  input  logic       HsRxEn,
  input  logic       DinHS,
  output logic [7:0] RxDataHS,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotSyncHS
);
  logic              older;
  logic              newer;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [HIST_W-1:0] hist;
  logic [HIST_W-1:0] shifted;
  logic [4:0]        hunt_cnt;
  logic [1:0]        pair_cnt;
  logic              phase_odd;
  logic [7:0]        win_even;
  logic [7:0]        win_odd;
  logic              match_even;
  logic              match_odd;
  logic              sync_nxt;
  logic              valid_nxt;
  logic              unused_hist;

  rx_ddr_capture u_capture (
    .clk   (RxDDRClkHS),
    .rst_n (RxRst),
    .din   (DinHS),
    .older (older),
    .newer (newer)
  );

  // Newest bits enter at the MSB so each window reads directly as an LSB-first byte.
  assign shifted     = {newer, older, hist[HIST_W-1:2]};
  assign win_even    = shifted[9:2];
  assign win_odd     = shifted[8:1];
  assign match_even  = (win_even == SYNC_BYTE);
  assign match_odd   = (win_odd == SYNC_BYTE);
  assign unused_hist = ^hist[1:0];

  assign RxActiveHS   = (state == ACTIVE);
  assign ErrSotSyncHS = (state == ERR);

  always_ff @(posedge RxDDRClkHS or negedge RxRst) begin
    if (!RxRst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sync_nxt  = 1'b0;
    valid_nxt = 1'b0;
    if (!HsRxEn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (match_even || match_odd) begin
            state_nxt = ACTIVE;
            sync_nxt  = 1'b1;
          end else if (hunt_cnt == 5'(HUNT_TIMEOUT - 1)) begin
            state_nxt = ERR;
          end
        end
        ACTIVE: valid_nxt = (pair_cnt == 2'd3);
        ERR: state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge RxDDRClkHS or negedge RxRst) begin
    if (!RxRst) begin
      hist      <= '0;
      hunt_cnt  <= '0;
      pair_cnt  <= '0;
      phase_odd <= 1'b0;
      RxDataHS  <= 8'h00;
      RxValidHS <= 1'b0;
      RxSyncHS  <= 1'b0;
    end else begin
      RxSyncHS  <= sync_nxt;
      RxValidHS <= valid_nxt;
      if (state == IDLE) begin
        // Holding everything clear in IDLE makes each new HUNT start from scratch.
        hist      <= '0;
        hunt_cnt  <= '0;
        pair_cnt  <= '0;
        phase_odd <= 1'b0;
      end else begin
        hist <= shifted;
        if (state == HUNT) hunt_cnt <= hunt_cnt + 5'd1;
        if (sync_nxt) begin
          phase_odd <= !match_even;
          pair_cnt  <= '0;
        end else if (state == ACTIVE) begin
          pair_cnt <= pair_cnt + 2'd1;
        end
      end
      if (valid_nxt) RxDataHS <= phase_odd ? win_odd : win_even;
    end
  end
endmodule
